// File: rtl/mem_resp_queue_pkg.sv
// Shared load op codes and width helpers for the MEM-stage response queue.
package mem_pkg;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_D  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;
  localparam logic [2:0] LD_WU = 3'd6;

  localparam int OP_W = 3;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_resp_queue_if.sv
// EXE request / data bus / MEM handshake bundle around the response queue.
interface mem_resp_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int OFF_W = mem_pkg::off_w(DATA_W);
  localparam int CNT_W = mem_pkg::cnt_w(DEPTH);

  logic              req_fire;
  logic              req_is_load;
  logic [2:0]        req_op;
  logic [OFF_W-1:0]  req_off;
  logic              full;
  logic [CNT_W-1:0]  outstanding;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_is_load;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_fire, req_is_load, req_op, req_off, data_ok, rdata, flush, resp_ready,
    input  full, outstanding, resp_valid, resp_is_load, resp_data
  );

  modport slave (
    input  req_fire, req_is_load, req_op, req_off, data_ok, rdata, flush, resp_ready,
    output full, outstanding, resp_valid, resp_is_load, resp_data
  );

endinterface

// File: rtl/mem_resp_queue_load_extend.sv
// Load lane select plus sign/zero extension for the head queue entry.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = off_w(DATA_W)
) (
  input  logic [2:0]        op_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] res_o
);

  logic [DATA_W-1:0] lane;

  assign lane = data_i >> {off_i, 3'b000};

  always_comb begin
    res_o = lane;
    unique case (op_i)
      LD_B:    res_o = DATA_W'($signed(lane[7:0]));
      LD_H:    res_o = DATA_W'($signed(lane[15:0]));
      LD_W:    res_o = DATA_W'($signed(lane[31:0]));
      LD_BU:   res_o = DATA_W'(lane[7:0]);
      LD_HU:   res_o = DATA_W'(lane[15:0]);
      LD_WU:   res_o = DATA_W'(lane[31:0]);
      default: res_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_resp_queue.sv
// In-order outstanding-request ring for the MEM stage: allocate on bus accept,
// complete on data_ok, retire to WB; flush cancels entries but keeps bus order.
module mem_resp_queue
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_resp_queue_if.slave bus
);

  localparam int OFF_W = off_w(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0]             vld_q, vld_d, done_q, done_d, cncl_q, cncl_d;
  logic [DEPTH-1:0]             is_load_q, is_load_d;
  logic [DEPTH-1:0][OP_W-1:0]   op_q, op_d;
  logic [DEPTH-1:0][OFF_W-1:0]  off_q, off_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             alloc_ptr_q, alloc_ptr_d, rsp_ptr_q, rsp_ptr_d, ret_ptr_q, ret_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic              full, alloc, has_unrsp, rsp, retire, resp_valid;
  logic              h_vld, h_done, h_cncl;
  logic [DATA_W-1:0] ext_res;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign alloc     = bus.req_fire & ~full;
  // Responses are in order, so the rsp_ptr slot is the only candidate for data_ok.
  assign has_unrsp = vld_q[rsp_ptr_q] & ~done_q[rsp_ptr_q];
  assign rsp       = bus.data_ok & has_unrsp;

  assign h_vld      = vld_q[ret_ptr_q];
  assign h_done     = done_q[ret_ptr_q];
  assign h_cncl     = cncl_q[ret_ptr_q];
  assign resp_valid = h_vld & h_done & ~h_cncl & ~bus.flush;
  assign retire     = (resp_valid & bus.resp_ready) | (h_vld & h_done & h_cncl);

  load_extend #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_ext (
    .op_i   (op_q[ret_ptr_q]),
    .off_i  (off_q[ret_ptr_q]),
    .data_i (data_q[ret_ptr_q]),
    .res_o  (ext_res)
  );

  assign bus.full         = full;
  assign bus.outstanding  = cnt_q;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_is_load = is_load_q[ret_ptr_q];
  assign bus.resp_data    = (resp_valid && is_load_q[ret_ptr_q]) ? ext_res : '0;

  always_comb begin
    vld_d       = vld_q;
    done_d      = done_q;
    cncl_d      = cncl_q;
    is_load_d   = is_load_q;
    op_d        = op_q;
    off_d       = off_q;
    data_d      = data_q;
    alloc_ptr_d = alloc_ptr_q;
    rsp_ptr_d   = rsp_ptr_q;
    ret_ptr_d   = ret_ptr_q;
    cnt_d       = cnt_q;

    if (bus.flush) cncl_d = cncl_q | vld_q;

    if (rsp) begin
      done_d[rsp_ptr_q] = 1'b1;
      data_d[rsp_ptr_q] = bus.rdata;
      rsp_ptr_d         = rsp_ptr_q + PTR_W'(1);
    end

    if (alloc) begin
      vld_d[alloc_ptr_q]     = 1'b1;
      done_d[alloc_ptr_q]    = 1'b0;
      cncl_d[alloc_ptr_q]    = bus.flush;
      is_load_d[alloc_ptr_q] = bus.req_is_load;
      op_d[alloc_ptr_q]      = bus.req_op;
      off_d[alloc_ptr_q]     = bus.req_off;
      alloc_ptr_d            = alloc_ptr_q + PTR_W'(1);
    end

    if (retire) begin
      vld_d[ret_ptr_q] = 1'b0;
      ret_ptr_d        = ret_ptr_q + PTR_W'(1);
    end

    unique case ({alloc, retire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q       <= '0;
      done_q      <= '0;
      cncl_q      <= '0;
      is_load_q   <= '0;
      op_q        <= '0;
      off_q       <= '0;
      data_q      <= '0;
      alloc_ptr_q <= '0;
      rsp_ptr_q   <= '0;
      ret_ptr_q   <= '0;
      cnt_q       <= '0;
    end else begin
      vld_q       <= vld_d;
      done_q      <= done_d;
      cncl_q      <= cncl_d;
      is_load_q   <= is_load_d;
      op_q        <= op_d;
      off_q       <= off_d;
      data_q      <= data_d;
      alloc_ptr_q <= alloc_ptr_d;
      rsp_ptr_q   <= rsp_ptr_d;
      ret_ptr_q   <= ret_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  a_no_fire_when_full: assert property (@(posedge clk) disable iff (reset) !(bus.req_fire && full));
  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset) !(bus.data_ok && !has_unrsp));

endmodule

// File: tb/tb_mem_resp_queue.sv
// Bench for mem_resp_queue: vector table, hand-written corner sequences, and a
// randomized run against a queue-based reference model.
module tb_mem_resp_queue;
  import mem_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_resp_queue_if #(.DATA_W(32), .DEPTH(DEPTH)) a ();
  mem_resp_queue_if #(.DATA_W(64), .DEPTH(DEPTH)) b ();

  mem_resp_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .reset(reset), .bus(a.slave));
  mem_resp_queue #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (.clk(clk), .reset(reset), .bus(b.slave));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          ld;
    logic [2:0]  op;
    int          off;
    logic [63:0] data;
    bit          done;
    bit          cncl;
  } ment_t;

  ment_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference extraction: arithmetic on masks, independent of the RTL lane logic.
  function automatic logic [63:0] ext_model(input logic [2:0] op, input int off,
                                            input logic [63:0] d, input int dw);
    int bits;
    bit sgn;
    logic [63:0] v, mask;
    case (op)
      LD_B, LD_BU: bits = 8;
      LD_H, LD_HU: bits = 16;
      LD_W, LD_WU: bits = 32;
      default:     bits = 64;
    endcase
    sgn  = (op <= LD_D);
    mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    v    = (d >> (off * 8)) & mask;
    if (sgn && bits < 64 && v[bits-1]) v = v | ~mask;
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic idle();
    a.req_fire = 0; a.req_is_load = 0; a.req_op = '0; a.req_off = '0;
    a.data_ok = 0; a.rdata = '0; a.flush = 0; a.resp_ready = 0;
    b.req_fire = 0; b.req_is_load = 0; b.req_op = '0; b.req_off = '0;
    b.data_ok = 0; b.rdata = '0; b.flush = 0; b.resp_ready = 0;
  endtask

  task automatic txn32(input string name, input logic [2:0] op, input logic [1:0] off,
                       input logic [31:0] rdata, input logic [31:0] exp);
    a.req_fire = 1; a.req_is_load = 1; a.req_op = op; a.req_off = off;
    tick();
    a.req_fire = 0; a.data_ok = 1; a.rdata = rdata;
    #1 chk({name, "_no_bypass"}, 64'(a.resp_valid), 64'd0);
    tick();
    a.data_ok = 0; a.resp_ready = 1;
    #1 chk({name, "_valid"}, 64'(a.resp_valid), 64'd1);
    chk({name, "_data"}, 64'(a.resp_data), 64'(exp));
    tick();
    a.resp_ready = 0;
  endtask

  task automatic txn64(input string name, input bit ld, input logic [2:0] op, input logic [2:0] off,
                       input logic [63:0] rdata, input logic [63:0] exp);
    b.req_fire = 1; b.req_is_load = ld; b.req_op = op; b.req_off = off;
    tick();
    b.req_fire = 0; b.data_ok = 1; b.rdata = rdata;
    tick();
    b.data_ok = 0; b.resp_ready = 1;
    #1 chk({name, "_valid"}, 64'(b.resp_valid), 64'd1);
    chk({name, "_is_load"}, 64'(b.resp_is_load), 64'(ld));
    chk({name, "_data"}, b.resp_data, exp);
    tick();
    b.resp_ready = 0;
  endtask

  // n word loads, n responses, optional stall, then n consecutive retires in order.
  task automatic batch32(input string name, input int n, input logic [31:0] base, input int hold);
    for (int i = 0; i < n; i++) begin
      a.req_fire = 1; a.req_is_load = 1; a.req_op = LD_W; a.req_off = '0;
      tick();
    end
    a.req_fire = 0;
    for (int i = 0; i < n; i++) begin
      a.data_ok = 1; a.rdata = base + 32'(i);
      tick();
    end
    a.data_ok = 0;
    for (int h = 0; h < hold; h++) begin
      #1 chk({name, "_held_valid"}, 64'(a.resp_valid), 64'd1);
      chk({name, "_held_data"}, 64'(a.resp_data), 64'(base));
      tick();
    end
    a.resp_ready = 1;
    for (int i = 0; i < n; i++) begin
      #1 chk({name, "_valid"}, 64'(a.resp_valid), 64'd1);
      chk({name, "_data"}, 64'(a.resp_data), 64'(base + 32'(i)));
      tick();
    end
    a.resp_ready = 0;
    #1 chk({name, "_drained"}, 64'(a.outstanding), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    logic [2:0] ops[6];
    vt[0] = '{LD_B,  2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
    vt[1] = '{LD_HU, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
    vt[2] = '{LD_H,  2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
    vt[3] = '{LD_BU, 2'd3, 32'h80FF_0000, 32'h0000_0080};
    vt[4] = '{LD_B,  2'd0, 32'h1234_567F, 32'h0000_007F};
    vt[5] = '{LD_W,  2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[6] = '{LD_BU, 2'd1, 32'h0000_AB00, 32'h0000_00AB};
    vt[7] = '{LD_H,  2'd0, 32'h0000_8001, 32'hFFFF_8001};
    ops = '{LD_B, LD_H, LD_W, LD_BU, LD_HU, LD_WU};

    idle();
    reset = 1;
    tick(); tick();
    #1;
    chk("rst_full", 64'(a.full), 64'd0);
    chk("rst_outstanding", 64'(a.outstanding), 64'd0);
    chk("rst_resp_valid", 64'(a.resp_valid), 64'd0);
    chk("rst_resp_data", 64'(a.resp_data), 64'd0);
    chk("rst64_resp_valid", 64'(b.resp_valid), 64'd0);
    reset = 0;
    tick();

    for (int i = 0; i < 8; i++) txn32($sformatf("vec%0d", i), vt[i].op, vt[i].off, vt[i].rdata, vt[i].exp);

    // fill to DEPTH, release one, then wrap the ring twice
    for (int i = 0; i < 4; i++) begin
      a.req_fire = 1; a.req_is_load = 1; a.req_op = LD_W; a.req_off = '0;
      tick();
    end
    a.req_fire = 0;
    #1 chk("fill_full", 64'(a.full), 64'd1);
    chk("fill_outstanding", 64'(a.outstanding), 64'd4);
    a.data_ok = 1; a.rdata = 32'hA0;
    tick();
    a.data_ok = 0; a.resp_ready = 1;
    #1 chk("fill_first_data", 64'(a.resp_data), 64'hA0);
    tick();
    a.resp_ready = 0;
    #1 chk("fill_not_full", 64'(a.full), 64'd0);
    chk("fill_outstanding3", 64'(a.outstanding), 64'd3);
    for (int i = 0; i < 3; i++) begin
      a.data_ok = 1; a.rdata = 32'hA1 + 32'(i);
      tick();
    end
    a.data_ok = 0; a.resp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fill_rest_data", 64'(a.resp_data), 64'(32'hA1 + 32'(i)));
      tick();
    end
    a.resp_ready = 0;
    batch32("wrap1", 4, 32'h1000, 0);
    batch32("wrap2", 4, 32'h2000, 0);

    batch32("stall", 3, 32'h3000, 10);

    // flush with one done and one pending entry
    a.resp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      a.req_fire = 1; a.req_is_load = 1; a.req_op = LD_W; a.req_off = '0;
      tick();
    end
    a.req_fire = 0; a.data_ok = 1; a.rdata = 32'h4444;
    tick();
    a.data_ok = 0;
    #1 chk("fl_pre_valid", 64'(a.resp_valid), 64'd1);
    a.flush = 1; a.resp_ready = 1;
    #1 chk("fl_valid_masked", 64'(a.resp_valid), 64'd0);
    chk("fl_outstanding2", 64'(a.outstanding), 64'd2);
    tick();
    a.flush = 0;
    #1 chk("fl_done_silent", 64'(a.resp_valid), 64'd0);
    chk("fl_outstanding2b", 64'(a.outstanding), 64'd2);
    tick();
    #1 chk("fl_outstanding1", 64'(a.outstanding), 64'd1);
    chk("fl_pend_valid", 64'(a.resp_valid), 64'd0);
    a.data_ok = 1; a.rdata = 32'h5555;
    tick();
    a.data_ok = 0;
    #1 chk("fl_pend_silent", 64'(a.resp_valid), 64'd0);
    tick();
    #1 chk("fl_outstanding0", 64'(a.outstanding), 64'd0);
    a.resp_ready = 0;
    txn32("fl_after", LD_W, 2'd0, 32'h6666_7777, 32'h6666_7777);

    // flush, alloc and data_ok all in one cycle
    a.req_fire = 1; a.req_is_load = 1; a.req_op = LD_W; a.req_off = '0;
    tick();
    a.flush = 1; a.data_ok = 1; a.rdata = 32'h7777; a.resp_ready = 1;
    #1 chk("same_valid", 64'(a.resp_valid), 64'd0);
    tick();
    a.flush = 0; a.data_ok = 0; a.req_fire = 0;
    #1 chk("same_valid2", 64'(a.resp_valid), 64'd0);
    chk("same_outstanding2", 64'(a.outstanding), 64'd2);
    tick();
    #1 chk("same_outstanding1", 64'(a.outstanding), 64'd1);
    a.data_ok = 1; a.rdata = 32'h8888;
    tick();
    a.data_ok = 0;
    #1 chk("same_valid3", 64'(a.resp_valid), 64'd0);
    tick();
    #1 chk("same_outstanding0", 64'(a.outstanding), 64'd0);
    a.resp_ready = 0;
    txn32("same_after", LD_HU, 2'd2, 32'h80FF_0000, 32'h0000_80FF);

    // 64-bit lanes
    txn64("w64",   1'b1, LD_W,  3'd4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    txn64("wu64",  1'b1, LD_WU, 3'd4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    txn64("d64",   1'b1, LD_D,  3'd0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
    txn64("h64",   1'b1, LD_H,  3'd6, 64'hF00D_0000_0000_0000, 64'hFFFF_FFFF_FFFF_F00D);
    txn64("st64",  1'b0, LD_W,  3'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);

    // randomized run vs queue model
    for (int c = 0; c < 1500; c++) begin
      bit fire, dok, fl, rdy, has_unrsp, exp_valid, retire;
      int uidx, off;
      logic [2:0] op;
      logic [31:0] rd;
      has_unrsp = 0; uidx = -1;
      for (int i = 0; i < mq.size(); i++)
        if (!mq[i].done && uidx < 0) begin has_unrsp = 1; uidx = i; end
      fire = (mq.size() < DEPTH) && ($urandom_range(1, 0) == 1);
      dok  = has_unrsp && ($urandom_range(2, 0) != 0);
      fl   = ($urandom_range(15, 0) == 0);
      rdy  = ($urandom_range(3, 0) != 0);
      op   = ops[$urandom_range(5, 0)];
      case (op)
        LD_B, LD_BU: off = $urandom_range(3, 0);
        LD_H, LD_HU: off = 2 * $urandom_range(1, 0);
        default:     off = 0;
      endcase
      rd = $urandom;
      a.req_fire = fire; a.req_is_load = ($urandom_range(3, 0) != 0); a.req_op = op;
      a.req_off = 2'(off); a.data_ok = dok; a.rdata = rd; a.flush = fl; a.resp_ready = rdy;
      #1;
      exp_valid = (mq.size() > 0) && mq[0].done && !mq[0].cncl && !fl;
      chk("rnd_full", 64'(a.full), 64'(mq.size() == DEPTH));
      chk("rnd_outstanding", 64'(a.outstanding), 64'(mq.size()));
      chk("rnd_valid", 64'(a.resp_valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("rnd_is_load", 64'(a.resp_is_load), 64'(mq[0].ld));
        chk("rnd_data", 64'(a.resp_data),
            mq[0].ld ? ext_model(mq[0].op, mq[0].off, mq[0].data, 32) : 64'd0);
      end
      retire = (mq.size() > 0) && mq[0].done && (mq[0].cncl || (!fl && rdy));
      if (dok) begin mq[uidx].done = 1; mq[uidx].data = 64'(rd); end
      if (fl) for (int i = 0; i < mq.size(); i++) mq[i].cncl = 1;
      if (fire) mq.push_back('{a.req_is_load, op, off, 64'd0, 1'b0, fl});
      if (retire) void'(mq.pop_front());
      tick();
    end
    idle();

    // reset mid-operation drops everything
    a.req_fire = 1; a.req_is_load = 1; a.req_op = LD_W; a.req_off = '0;
    tick();
    a.req_fire = 0;
    reset = 1;
    #1 chk("midrst_outstanding", 64'(a.outstanding), 64'd0);
    chk("midrst_full", 64'(a.full), 64'd0);
    chk("midrst_valid", 64'(a.resp_valid), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
